uart_tx_serializer: RTL and testbench

- UART transmitter for the uart2sram path. Serializes bytes from an upstream valid/ready source onto txd as 8N1 frames (configurable).
- Bit timing comes from the existing baud-rate generator's 16x-oversample square-wave output, which drives baud_clk. It is synchronous to clk.
- One bit period is OVERSAMPLE rising edges of baud_clk.

---
 rtl/uart_tx_serializer.sv | 124 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: UART transmitter, bit timing from rising edges of a 16x baud_clk.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = $clog2(OVERSAMPLE);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t               state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 baud_q, txd_q, txd_d, ready_q, busy_q, done_q, done_d;
    logic                 tick, accept, wrap;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign tick     = baud_clk & ~baud_q;
    assign accept   = tx_valid & ready_q;
    assign wrap     = tick && tick_cnt_q == TW'(OVERSAMPLE - 1);
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign txd      = txd_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        if (state_q != IDLE && tick)
            tick_cnt_d = wrap ? '0 : tick_cnt_q + 1'b1;
        case (state_q)
            IDLE: if (accept) begin
                state_d    = START;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                shift_d    = tx_data;
`ifdef UART_TX_PARITY_EN
                par_d      = ^tx_data;
`endif
            end
            START: if (wrap) state_d = DATA;
            DATA: if (wrap) begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    state_d   = PARITY;
`else
                    state_d   = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (wrap) state_d = STOP;
`endif
            STOP: if (wrap) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // txd is registered from the next state so reset and transitions never glitch the line
        txd_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_d == PARITY) txd_d = par_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            baud_q     <= 1'b0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            baud_q     <= baud_clk;
            txd_q      <= txd_d;
            ready_q    <= state_d == IDLE;
            busy_q     <= state_d != IDLE;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed frames against two instances (1 and 2 stop bits),
// bits sampled mid-period by counting baud_clk rising edges.
module tb_uart_tx_serializer;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, baud_clk = 1'b0, baud_d = 1'b0;
    logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
    logic       tx_valid = 1'b0, tx_valid2 = 1'b0, sel = 1'b0;
    logic       tx_ready, txd, tx_busy, tx_done;
    logic       tx_ready2, txd2, tx_busy2, tx_done2;
    logic       txd_m, busy_m, done_m, tick_tb;
    int         div = 0, done_cnt = 0, n_cmp = 0, n_err = 0;

    uart_tx_serializer dut (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .txd(txd), .tx_busy(tx_busy), .tx_done(tx_done)
    );
    uart_tx_serializer #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .txd(txd2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    always #5 clk = ~clk;
    // 100 MHz / 54 clks per baud_clk period, as from the real generator
    always @(posedge clk) begin
        div      <= (div == 26) ? 0 : div + 1;
        baud_clk <= (div == 26) ? ~baud_clk : baud_clk;
        baud_d   <= baud_clk;
        if (tx_done) done_cnt <= done_cnt + 1;
    end
    assign tick_tb = baud_clk & ~baud_d;
    assign txd_m   = sel ? txd2 : txd;
    assign busy_m  = sel ? tx_busy2 : tx_busy;
    assign done_m  = sel ? tx_done2 : tx_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] frame_bits(input logic [7:0] d);
        logic [11:0] f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = d[i];
        if (PAR == 1) f[9] = ^d;
        return f;
    endfunction

    task automatic wait_busy(input logic v);
        int g = 0;
        while (busy_m !== v && g < 20000) begin @(negedge clk); g++; end
        if (g >= 20000) check("busy_timeout", busy_m, v);
    endtask

    task automatic send(input logic [7:0] d);
        if (sel) begin tx_data2 = d; tx_valid2 = 1'b1; end
        else begin tx_data = d; tx_valid = 1'b1; end
        wait_busy(1'b1);
        tx_valid = 1'b0;
        tx_valid2 = 1'b0;
    endtask

    // Waits for the start bit, samples every bit at its middle tick, records the tick count at tx_done.
    task automatic watch(input string tag, input logic [7:0] d, input int stops);
        int t = 0, last = -1, done_at = -1, g = 0, n = 9 + PAR + stops;
        logic [11:0] got = '1;
        while (txd_m !== 1'b0 && g < 30000) begin @(negedge clk); g++; end
        if (g >= 30000) begin check({tag, "_start"}, txd_m, 0); return; end
        g = 0;
        while (g < 20000) begin
            if (t != last && t % 16 == 8 && t / 16 < n) begin got[t/16] = txd_m; last = t; end
            if (done_m) begin done_at = t; break; end
            if (tick_tb) t++;
            @(negedge clk);
            g++;
        end
        check({tag, "_bits"}, got, frame_bits(d));
        check({tag, "_len"}, done_at, n * 16);
    endtask

    initial begin
        int t, g;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("rst_txd", txd, 1);
            check("rst_ready", tx_ready, 1);
            check("rst_busy", tx_busy, 0);
            check("rst_done", tx_done, 0);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check("idle_txd", txd, 1);
        check("idle_busy", tx_busy, 0);

        fork send(8'h55); watch("b55", 8'h55, 1); join
        repeat (100) @(negedge clk);
        check("b55_donecnt", done_cnt, 1);

        fork
            begin
                tx_data = 8'hA5;
                tx_valid = 1'b1;
                wait_busy(1'b1);
                tx_data = 8'h3C;
                wait_busy(1'b0);
                wait_busy(1'b1);
                tx_valid = 1'b0;
                tx_data = 8'hFF;
            end
            begin
                watch("bA5", 8'hA5, 1);
                check("gap_hi", txd, 1);
                @(negedge clk);
                check("gap_lo", txd, 0);
                watch("b3C", 8'h3C, 1);
            end
        join

        fork
            begin
                send(8'h5A);
                repeat (3000) @(negedge clk);
                tx_data = 8'hFF;
                tx_valid = 1'b1;
                repeat (5) begin @(negedge clk); check("busy_ready", tx_ready, 0); end
                tx_valid = 1'b0;
            end
            watch("b5A", 8'h5A, 1);
        join
        repeat (3000) @(negedge clk);
        check("busy_after_txd", txd, 1);
        check("busy_after_busy", tx_busy, 0);
        check("busy_donecnt", done_cnt, 4);

        fork
            send(8'h00);
            begin
                g = 0;
                t = 0;
                while (txd !== 1'b0 && g < 30000) begin @(negedge clk); g++; end
                while (t < 72 && g < 30000) begin if (tick_tb) t++; @(negedge clk); g++; end
            end
        join
        check("abort_pre_txd", txd, 0);
        #2 rst_n = 1'b0;
        #1 check("abort_txd", txd, 1);
        check("abort_busy", tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        fork send(8'h81); watch("b81", 8'h81, 1); join

        sel = 1'b1;
        fork send(8'h07); watch("s2_07", 8'h07, 2); join
        sel = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
